// File: rtl/sensor_ctrl_pkg.sv
// rtl/sensor_ctrl_pkg.sv - shared state encoding and sizing helpers for the sensor sampler
package sensor_ctrl_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_PERIOD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ENABLE,
    ST_CAPTURE,
    ST_EMIT
  } state_t;

  // Samples per burst; used as a localparam in the top level.
  function automatic int burst_len(input int avg_log2);
    return 1 << avg_log2;
  endfunction

endpackage

// File: rtl/sensor_period_timer.sv
// rtl/sensor_period_timer.sv - loadable down-counter flagging the last cycle of a timed state
module sensor_period_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Loaded on entry to a timed state; counts down and parks at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A load of L keeps the owning state for exactly L cycles; done marks the last one.
  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/sensor_sampler.sv
// rtl/sensor_sampler.sv - periodic burst sampler that averages sensor reads onto a valid/ready stream
module sensor_sampler
  import sensor_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int PERIOD_W = DEFAULT_PERIOD_W,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_sensor_enable,
  input  logic [DATA_W-1:0]   i_sensor_data,
  output logic [DATA_W-1:0]   o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_busy,
  output logic                o_overrun,
  input  logic                i_clear_overrun
);

  localparam int N     = burst_len(AVG_LOG2);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  state_t              r_state;
  logic                r_sensor_enable;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_overrun;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_count;

  logic                w_tmr_load;
  logic [PERIOD_W-1:0] w_tmr_val;
  logic                w_tmr_done;
  logic                w_more;

  assign w_more = (int'(r_count) < N - 1);

  // Timer is reloaded on every entry to WAIT (with period) or ENABLE (with SETTLE).
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      ST_IDLE, ST_EMIT: begin
        if (i_start) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (i_period != '0) ? i_period : PERIOD_W'(SETTLE);
        end
      end
      ST_WAIT: begin
        if (i_start && w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = PERIOD_W'(SETTLE);
        end
      end
      ST_CAPTURE: begin
        if (w_more) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = PERIOD_W'(SETTLE);
        end
      end
      default: ;
    endcase
  end

  sensor_period_timer #(
    .W(PERIOD_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Burst sequencing, accumulation and the output handshake with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_sensor_enable <= 1'b0;
      r_out_data      <= '0;
      r_out_valid     <= 1'b0;
      r_overrun       <= 1'b0;
      r_acc           <= '0;
      r_count         <= '0;
    end else begin
      if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
      if (i_clear_overrun) r_overrun <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_period != '0) begin
              r_state <= ST_WAIT;
            end else begin
              r_state         <= ST_ENABLE;
              r_sensor_enable <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!i_start) begin
            r_state <= ST_IDLE;
          end else if (w_tmr_done) begin
            r_state         <= ST_ENABLE;
            r_sensor_enable <= 1'b1;
          end
        end
        ST_ENABLE: begin
          if (w_tmr_done) begin
            r_state         <= ST_CAPTURE;
            r_sensor_enable <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          r_acc <= r_acc + ACC_W'(i_sensor_data);
          if (w_more) begin
            r_count         <= r_count + 1'b1;
            r_state         <= ST_ENABLE;
            r_sensor_enable <= 1'b1;
          end else begin
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          r_out_data  <= DATA_W'(r_acc >> AVG_LOG2);
          r_out_valid <= 1'b1;
          if (r_out_valid && !i_out_ready) r_overrun <= 1'b1;
          r_acc   <= '0;
          r_count <= '0;
          if (!i_start) begin
            r_state <= ST_IDLE;
          end else if (i_period != '0) begin
            r_state <= ST_WAIT;
          end else begin
            r_state         <= ST_ENABLE;
            r_sensor_enable <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sensor_enable = r_sensor_enable;
  assign o_out_data      = r_out_data;
  assign o_out_valid     = r_out_valid;
  assign o_overrun       = r_overrun;
  assign o_busy          = (r_state != ST_IDLE);

endmodule

// File: doc/sensor_sampler.md
Name: sensor_sampler

Overview:
Controller and reader on the other side of the sensor interface: drives the sensor's enable, waits for its registered output, and captures samples.
- Runs periodic bursts of 2^AVG_LOG2 samples and averages each burst.
- Presents each average on a valid/ready stream to the node's packetiser.
- Sits between the sensor block and the transmit path of the wireless sensor node.

Parameters:
DATA_W, 8, sensor data width (matches the 8-bit sensor bus)
PERIOD_W, 16, width of the inter-burst period counter
AVG_LOG2, 2, log2 of samples per burst (0 = no averaging, max 4)
SETTLE, 1, sensor_enable cycles per sample before capture (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  level; high = run periodic sampling
period  in  PERIOD_W  idle cycles between bursts; latched on leaving IDLE
sensor_enable  out  1  enable to sensor
sensor_data  in  DATA_W  registered sensor output
out_data  out  DATA_W  averaged sample
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid & out_ready
busy  out  1  state != IDLE
overrun  out  1  sticky; an unaccepted result was overwritten
clear_overrun  in  1  clears overrun

Behaviour:
Interface:
- Single clock domain, clk.
- rst is synchronous, active-high.
- All outputs are registered except busy, which is decoded from state.

Reset:
- state=IDLE; sensor_enable, out_valid and overrun are 0.
- out_data, the accumulator, the sample count and the period counter are 0.
- rst asserted mid-burst aborts it; no partial result is emitted.

FSM states: IDLE, WAIT, ENABLE, CAPTURE, EMIT.
- IDLE: start=1 -> latch period into period_q. Next state is WAIT if period_q!=0, else ENABLE.
- WAIT: counts period_q cycles, then ENABLE. start=0 in WAIT -> IDLE immediately.
- ENABLE: sensor_enable=1 for exactly SETTLE cycles, then CAPTURE.
- CAPTURE: sensor_enable=0.
  - Add sensor_data into the accumulator (width DATA_W+AVG_LOG2, zero-extended).
  - The sensor registers data on each enabled edge, so the value seen in CAPTURE is the one sampled at the last ENABLE edge.
  - If sample count < 2^AVG_LOG2-1: increment count, go to ENABLE.
  - Otherwise go to EMIT.
- EMIT:
  - out_data <= accumulator >> AVG_LOG2, truncating.
  - out_valid <= 1.
  - Accumulator and count clear.
  - Next state: start=1 -> WAIT, or ENABLE if period_q==0, with period_q re-latched from period. start=0 -> IDLE.
- start=0 during ENABLE/CAPTURE does not abort; the burst completes and is emitted.

Timing:
- First ENABLE cycle = cycle 0.
- out_valid is visible at cycle N*(SETTLE+1)+1, where N=2^AVG_LOG2.
- Burst-to-burst spacing is period_q + N*(SETTLE+1) + 1 cycles.

Output handshake:
- Transfer occurs when out_valid & out_ready; out_valid drops the next cycle unless EMIT reloads it.
- out_data is stable while out_valid=1 and out_ready=0, except on overwrite.
- EMIT while out_valid=1 and out_ready=0: out_data is overwritten with the new result, out_valid stays 1, overrun <= 1.
- EMIT in the same cycle as a transfer: new data loads, out_valid stays 1, no overrun.
- clear_overrun and a new overrun in the same cycle: set wins.
- out_valid and out_data persist through IDLE until accepted.

Arithmetic:
- The accumulator cannot overflow: its width is DATA_W+AVG_LOG2.
- Truncation is floor division.

Decomposition:
- Package sensor_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, ENABLE, CAPTURE, EMIT);
  - default DATA_W/PERIOD_W constants;
  - the localparam form of N = 1<<AVG_LOG2.
- One natural sub-module: sensor_period_timer. It is a loadable down-counter with a done pulse and is reused for both the WAIT and SETTLE counts.

Test Plan:
1. Bench instantiates the sensor model driven by a bench environment value.
   - Stimulus: AVG_LOG2=0, SETTLE=1, period=3, environment=8'h5A, out_ready=1, start=1.
   - Required: sensor_enable pulses 1 cycle every 6 cycles; out_data=8'h5A with out_valid at cycle 3 after each ENABLE start.
2. Stimulus: AVG_LOG2=2, environment = 10, 20, 30, 41 across the four ENABLE windows.
   - Required: out_data = 101>>2 = 25, a single out_valid per burst.
3. Stimulus: out_ready=0, period=0, AVG_LOG2=0; two bursts complete.
   - Required: out_valid stays 1, out_data equals the second sample, overrun=1.
   - Then: clear_overrun pulse -> overrun=0; out_ready=1 -> one transfer, out_valid=0.
4. Stimulus: start deasserted during the second ENABLE cycle of a SETTLE=2 burst.
   - Required: burst completes, result emitted, FSM returns to IDLE, busy=0, no further sensor_enable.
   - Stimulus: start deasserted in WAIT.
   - Required: IDLE next cycle, no emit.
5. Stimulus: rst pulsed mid-CAPTURE with AVG_LOG2=2 after 2 samples.
   - Required: all outputs 0 next cycle; on restart the next burst averages 4 fresh samples with no residue from the aborted burst.
6. Stimulus: EMIT coincides with a transfer of the previous result.
   - Required: both values observed by the consumer in order, overrun remains 0.
